// File: rtl/filter_resize_frame_sched_if.sv
// Control/status and per-stage ap_ctrl_hs bundle for the frame scheduler.
interface filter_resize_frame_sched_if #(
    parameter int CNT_W = 16
);
    logic             cfg_start;
    logic             cfg_stop;
    logic [CNT_W-1:0] cfg_frames;
    logic [3:0]       stage_start;
    logic [3:0]       stage_ready;
    logic [3:0]       stage_done;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames_done;
    logic             err;

    modport master (
        output cfg_start, cfg_stop, cfg_frames, stage_ready, stage_done,
        input  stage_start, busy, done, frames_done, err
    );

    modport slave (
        input  cfg_start, cfg_stop, cfg_frames, stage_ready, stage_done,
        output stage_start, busy, done, frames_done, err
    );
endinterface

// File: rtl/filter_resize_frame_sched.sv
// Frame scheduler for the data_in/filter_proc/resize_proc/data_out chain.
// Issues ap_ctrl_hs starts in frame order with a cap on frames in flight.
module filter_resize_frame_sched #(
    parameter int CNT_W        = 16,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    filter_resize_frame_sched_if.slave  bus
);
    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_started   [4];
    logic [CNT_W-1:0] r_completed [4];
    logic [3:0]       r_start;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [3:0]       w_elig;
    logic [3:0]       w_start_nx;
    logic [CNT_W-1:0] w_started_nx   [4];
    logic [CNT_W-1:0] w_completed_nx [4];
    logic [CNT_W-1:0] w_inflight;
    logic             w_spur;
    logic             w_drained;

    assign w_inflight = r_started[0] - r_completed[3];

    always_comb begin
        w_elig    = '0;
        w_elig[0] = (r_state == S_RUN) && !bus.cfg_stop &&
                    (r_started[0] < r_target) && (w_inflight < LP_MAX);
        for (int i = 1; i < 4; i++) begin
            w_elig[i] = (r_state != S_IDLE) &&
                        (r_started[i] < r_started[i-1]);
        end
    end

    // A pending start is held until ready; a fresh one only after a gap.
    always_comb begin
        w_start_nx = '0;
        w_spur     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_started_nx[i]   = r_started[i];
            w_completed_nx[i] = r_completed[i];
            if (r_start[i]) begin
                w_start_nx[i] = !bus.stage_ready[i];
                if (bus.stage_ready[i]) begin
                    w_started_nx[i] = r_started[i] + CNT_W'(1);
                end
            end else begin
                w_start_nx[i] = w_elig[i];
            end
            if (bus.stage_done[i]) begin
                if (r_completed[i] < r_started[i]) begin
                    w_completed_nx[i] = r_completed[i] + CNT_W'(1);
                end else begin
                    w_spur = 1'b1;
                end
            end
        end
        w_drained = (w_start_nx == '0) &&
                    (w_completed_nx[3] == w_started_nx[0]);
        for (int i = 1; i < 4; i++) begin
            if (w_started_nx[i] != w_started_nx[0]) begin
                w_drained = 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state  <= S_IDLE;
            r_target <= '0;
            r_start  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_started[i]   <= '0;
                r_completed[i] <= '0;
            end
        end else begin
            r_done  <= 1'b0;
            r_start <= w_start_nx;
            r_err   <= r_err | w_spur;
            for (int i = 0; i < 4; i++) begin
                r_started[i]   <= w_started_nx[i];
                r_completed[i] <= w_completed_nx[i];
            end
            unique case (r_state)
                S_IDLE: begin
                    if (bus.cfg_start) begin
                        r_target <= bus.cfg_frames;
                        r_err    <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            r_started[i]   <= '0;
                            r_completed[i] <= '0;
                        end
                        if (bus.cfg_frames != '0) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.cfg_stop || (r_started[0] == r_target)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stage_start = r_start;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.frames_done = r_completed[3];
    assign bus.err         = r_err;
endmodule

// File: tb/tb_filter_resize_frame_sched.sv
// Bench for filter_resize_frame_sched: stage responders plus a frame-count
// model of the schedule; directed vectors, corner sequences, random runs.
module tb_filter_resize_frame_sched;
    localparam int CNT_W = 16;
    localparam int MAXF  = 2;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    filter_resize_frame_sched_if #(.CNT_W(CNT_W)) bus ();

    filter_resize_frame_sched #(
        .CNT_W       (CNT_W),
        .MAX_INFLIGHT(MAXF)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .bus   (bus)
    );

    typedef struct {
        int         frames;
        int         lat;
        int         pct;
        logic [3:0] mask;
        int         stop_after;
        int         lo;
        int         hi;
    } vec_t;

    vec_t       tbl [6];
    int         checks = 0;
    int         failures = 0;
    int         acc [4];
    int         cmp [4];
    bit         exp_err;
    int         due [4][$];
    int         cyc = 0;
    int         lat = 1;
    int         rdy_pct = 100;
    logic [3:0] rdy_mask = 4'hF;
    int         hold2_left = 0;
    int         m_final = 0;
    int         done_seen = 0;

    task automatic chk_t(input string nm, input bit ok,
                         input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic chk_eq(input string nm, input longint act,
                          input longint req);
        chk_t(nm, act == req, act, req);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            acc[i] = 0;
            cmp[i] = 0;
            due[i].delete();
        end
        exp_err   = 1'b0;
        done_seen = 0;
    endtask

    // One clock: account for the handshakes the coming edge will take,
    // check the state after it, then drive the stage responders.
    task automatic tick();
        logic [3:0] st;
        logic [3:0] ac;
        logic [3:0] dn;
        bit         fin;
        st  = bus.stage_start;
        ac  = st & bus.stage_ready;
        dn  = bus.stage_done;
        fin = dn[3] && (cmp[3] < acc[3]) && (cmp[3] + 1 == m_final);
        for (int i = 0; i < 4; i++) begin
            if (dn[i]) begin
                if (cmp[i] < acc[i]) cmp[i]++;
                else exp_err = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (ac[i]) begin
                acc[i]++;
                due[i].push_back(cyc + lat);
            end
        end
        @(posedge ap_clk);
        cyc++;
        @(negedge ap_clk);
        chk_eq("frames_done", bus.frames_done, cmp[3]);
        chk_eq("err", bus.err, exp_err);
        chk_t("inflight", acc[0] - cmp[3] <= MAXF, acc[0] - cmp[3], MAXF);
        for (int i = 0; i < 4; i++) begin
            if (st[i] && !ac[i])
                chk_eq($sformatf("hold%0d", i), bus.stage_start[i], 1);
            if (ac[i])
                chk_eq($sformatf("gap%0d", i), bus.stage_start[i], 0);
        end
        for (int i = 1; i < 4; i++) begin
            if (bus.stage_start[i])
                chk_t($sformatf("order%0d", i), acc[i] < acc[i-1],
                      acc[i], acc[i-1]);
        end
        if (fin) begin
            chk_eq("done_after_last", bus.done, 1);
            chk_eq("busy_after_last", bus.busy, 0);
        end
        if (bus.done) begin
            done_seen++;
            chk_t("done_early",
                  cmp[3] == acc[0] && acc[1] == acc[0] &&
                  acc[2] == acc[0] && acc[3] == acc[0], cmp[3], acc[0]);
        end
        for (int i = 0; i < 4; i++) begin
            bus.stage_done[i] = 1'b0;
            if (due[i].size() > 0 && due[i][0] <= cyc) begin
                void'(due[i].pop_front());
                bus.stage_done[i] = 1'b1;
            end
            bus.stage_ready[i] = rdy_mask[i] &&
                                 ($urandom_range(0, 99) < rdy_pct);
        end
        if (hold2_left > 0) begin
            bus.stage_ready[2] = 1'b0;
            if (bus.stage_start[2]) hold2_left--;
        end
    endtask

    task automatic run_case(input string nm, input vec_t v);
        int n;
        bit stopped;
        model_clear();
        lat      = v.lat;
        rdy_pct  = v.pct;
        rdy_mask = v.mask;
        m_final  = (v.stop_after == 0 || v.stop_after >= v.frames) ?
                   v.frames : 0;
        bus.cfg_frames = CNT_W'(v.frames);
        bus.cfg_start  = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        chk_eq({nm, "_busy_on"}, bus.busy, (v.frames != 0) ? 1 : 0);
        chk_eq({nm, "_start_lat"}, bus.stage_start, 0);
        if (v.frames == 0) begin
            chk_eq({nm, "_zero_done"}, bus.done, 1);
            tick();
            chk_eq({nm, "_zero_done_off"}, bus.done, 0);
            chk_eq({nm, "_zero_starts"}, bus.stage_start, 0);
        end else begin
            tick();
            chk_eq({nm, "_s0_rise"}, bus.stage_start[0], 1);
            n = 0;
            stopped = 1'b0;
            while (!bus.done && n < 3000) begin
                if (v.stop_after != 0 && !stopped &&
                    acc[0] >= v.stop_after) begin
                    bus.cfg_stop = 1'b1;
                    stopped = 1'b1;
                end
                tick();
                bus.cfg_stop = 1'b0;
                n++;
            end
            chk_t({nm, "_timeout"}, n < 3000, n, 3000);
        end
        chk_t({nm, "_frames"},
              bus.frames_done >= v.lo && bus.frames_done <= v.hi,
              bus.frames_done, v.lo);
        chk_eq({nm, "_busy_end"}, bus.busy, 0);
        chk_eq({nm, "_err_end"}, bus.err, 0);
        for (int i = 0; i < 4; i++)
            chk_eq($sformatf("%s_starts%0d", nm, i), acc[i], cmp[3]);
        repeat (3) tick();
        chk_eq({nm, "_done_pulses"}, done_seen, 1);
    endtask

    initial begin
        vec_t rv;
        int   n;
        tbl[0] = '{3, 5, 100, 4'hF, 0, 3, 3};
        tbl[1] = '{10, 5, 100, 4'hF, 4, 4, 5};
        tbl[2] = '{0, 1, 100, 4'hF, 0, 0, 0};
        tbl[3] = '{7, 2, 50, 4'hF, 0, 7, 7};
        tbl[4] = '{1, 1, 100, 4'hF, 0, 1, 1};
        tbl[5] = '{5, 9, 70, 4'hF, 1, 1, 2};

        bus.cfg_start   = 1'b0;
        bus.cfg_stop    = 1'b0;
        bus.cfg_frames  = '0;
        bus.stage_ready = '0;
        bus.stage_done  = '0;
        model_clear();
        repeat (3) @(negedge ap_clk);
        chk_eq("rst_busy", bus.busy, 0);
        chk_eq("rst_done", bus.done, 0);
        chk_eq("rst_starts", bus.stage_start, 0);
        chk_eq("rst_frames", bus.frames_done, 0);
        chk_eq("rst_err", bus.err, 0);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        for (int k = 0; k < 6; k++)
            run_case($sformatf("vec%0d", k), tbl[k]);

        bus.stage_done = 4'b0010;
        tick();
        chk_eq("spur_err", bus.err, 1);
        chk_eq("spur_frames", bus.frames_done, cmp[3]);

        hold2_left = 10;
        rv = '{3, 3, 100, 4'hF, 0, 3, 3};
        run_case("hold2", rv);
        chk_eq("hold2_used", hold2_left, 0);

        for (int k = 0; k < 8; k++) begin
            rv.frames     = $urandom_range(1, 12);
            rv.lat        = $urandom_range(1, 8);
            rv.pct        = $urandom_range(30, 100);
            rv.mask       = 4'hF;
            rv.stop_after = ($urandom_range(0, 2) == 0) ?
                            $urandom_range(1, rv.frames) : 0;
            if (rv.stop_after == 0 || rv.stop_after >= rv.frames) begin
                rv.lo = rv.frames;
                rv.hi = rv.frames;
            end else begin
                rv.lo = rv.stop_after;
                rv.hi = rv.stop_after + 1;
            end
            run_case($sformatf("rnd%0d", k), rv);
        end

        model_clear();
        lat      = 50;
        rdy_pct  = 100;
        rdy_mask = 4'b0001;
        m_final  = 0;
        bus.cfg_frames = CNT_W'(10);
        bus.cfg_start  = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        n = 0;
        while (bus.stage_start != 4'b0011 && n < 50) begin
            tick();
            n++;
            if (acc[0] >= 1) begin
                rdy_mask = 4'b0000;
                bus.stage_ready = 4'b0000;
            end
        end
        chk_t("rst_mid_reach", bus.stage_start == 4'b0011,
              bus.stage_start, 3);
        #2 ap_rst = 1'b1;
        #1;
        chk_eq("rst_mid_starts", bus.stage_start, 0);
        chk_eq("rst_mid_busy", bus.busy, 0);
        chk_eq("rst_mid_done", bus.done, 0);
        chk_eq("rst_mid_frames", bus.frames_done, 0);
        chk_eq("rst_mid_err", bus.err, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        model_clear();
        bus.stage_done  = '0;
        bus.stage_ready = '0;
        rv = '{2, 3, 100, 4'hF, 0, 2, 2};
        run_case("after_rst", rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/filter_resize_frame_sched.md
# filter_resize_frame_sched

Frame-level scheduler that sequences the four filter_resize pipeline stages: data_in, filter_proc, resize_proc and data_out. It runs a programmed number of frames through the stages using the ap_ctrl_hs start/ready/done handshake. It keeps per-stage frame ordering and caps the number of frames in flight. On completion or on a stop request it drains cleanly and reports status.

## Interface
Parameters:
- CNT_W, 16: width of frame counters and of cfg_frames.
- MAX_INFLIGHT, 2: maximum frames started at stage 0 but not yet done at stage 3 (range 1..2^CNT_W-1).

Ports:
- ap_clk  in  1  sole clock; everything is rising-edge.
- ap_rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; starts a run when idle.
- cfg_stop  in  1  level or pulse; requests an early drain.
- cfg_frames  in  CNT_W  number of frames to run; sampled on accepted cfg_start.
- stage_start  out  4  ap_start per stage (bit0 data_in … bit3 data_out).
- stage_ready  in  4  ap_ready per stage.
- stage_done  in  4  ap_done per stage; one-cycle pulse per frame.
- busy  out  1  high while state ≠ IDLE.
- done  out  1  one-cycle pulse when a run ends.
- frames_done  out  CNT_W  frames completed by stage 3 in the current or last run.
- err  out  1  sticky; set when a stage reports done with no outstanding frame.

## Operation
- State machine: IDLE, RUN, DRAIN.
- Per-stage counters: started[i] and completed[i], each CNT_W bits. They are cleared on accepted cfg_start and never wrap, because cfg_frames bounds them.
- target is the latched cfg_frames.
- IDLE:
  - cfg_start with cfg_frames≠0: latch target, clear counters, clear err, clear frames_done, go to RUN.
  - cfg_start with cfg_frames=0: clear the same state, stay in IDLE, pulse done the next cycle.
- RUN, stage 0 eligibility: started[0]<target and started[0]-completed[3]<MAX_INFLIGHT.
- RUN/DRAIN, stage i>0 eligibility: started[i]<started[i-1].
- Start handshake:
  - Each stage_start bit is registered. It rises the cycle after the stage becomes eligible and no start is pending.
  - Once high, it is held until sampled with stage_ready[i]=1. That edge increments started[i] and drops stage_start[i].
  - stage_start[i] stays low for at least one cycle after every acceptance.
- stage_done[i]:
  - If completed[i]<started[i], increment completed[i].
  - Otherwise set err and leave the counter unchanged.
- frames_done mirrors completed[3].
- RUN→DRAIN when cfg_stop=1 or started[0]=target. Stage 0 eligibility is then forced false.
- A stage_start already high is never withdrawn, including stage 0 on stop; it completes its handshake and counts.
- DRAIN→IDLE when all of the following hold:
  - no stage_start is high;
  - started[i]=started[0] for every i;
  - completed[3]=started[0].
- On the DRAIN→IDLE edge, done pulses for one cycle.
- cfg_start while busy is ignored. cfg_stop in IDLE has no effect.
- Simultaneous start acceptance and done on the same stage in one cycle: both counters update.

## Timing
- Reset values: state IDLE, stage_start=0, busy=0, done=0, frames_done=0, err=0, all counters 0. Reset is asynchronous and applies immediately mid-run; the stages must be reset alongside.
- Accepted cfg_start at edge T: busy=1 after T, stage_start[0]=1 after T+1.
- Stage i+1 start rises no earlier than one cycle after the edge accepting stage i's start for the same frame.
- Minimum spacing between successive accepted starts on one stage is 2 cycles.
- Final stage_done[3] sampled at edge E: done=1 and busy=0 during the cycle after E, provided all starts have been accepted.
- Zero-frame run: done pulses the cycle after cfg_start, and busy never rises.

## Test plan
- cfg_frames=3, MAX_INFLIGHT=2, stages ready immediately with done 5 cycles after ready → 3 accepted starts per stage, frames_done=3, one done pulse, err=0, started[0]-completed[3] never exceeds 2.
- stage_ready[2] held low for 10 cycles → stage_start[2] stays high throughout; stage 3 is never started ahead of stage 2; ordering holds.
- cfg_frames=10, cfg_stop pulsed after 4 starts on stage 0 → frames_done=4 (or 5 if stage_start[0] was pending at the stop), all stages equal, done pulse.
- Spurious stage_done[1] in IDLE → err=1, counters unchanged; err clears on the next cfg_start.
- cfg_frames=0 → done pulse one cycle later, no stage_start, busy stays 0.
- ap_rst asserted mid-RUN with stage_start=4'b0011 → all outputs 0 immediately; a new cfg_start runs normally.
